// File: rtl/set_assoc_cache_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : set_assoc_cache_param                                        |
// | Description : N-way set-associative write-through / write-allocate cache   |
// |               with FIFO or true-LRU replacement and a req/ack memory port. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module set_assoc_cache_param #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int WAYS      = 4,
  parameter int SETS      = 256,
  parameter int REPL_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_write,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    flush,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_hit,
  output logic [$clog2(WAYS)-1:0] cpu_way,
  output logic                    busy,
  output logic                    mem_req,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam logic [ADDR_W-1:0] c_line_mask = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [1:0] {IDLE = 2'd0, MEM_RD = 2'd1, MEM_WR = 2'd2} state_t;
  state_t r_state, w_state_next;

  // Line storage and replacement metadata
  logic [WAYS-1:0]   r_valid [SETS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [DATA_W-1:0] r_data  [SETS][WAYS];
  logic [WAY_W-1:0]  r_ptr   [SETS];
  logic [WAY_W-1:0]  r_age   [SETS][WAYS];

  // Request context held across the memory access
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_req_tag;
  logic [WAY_W-1:0] r_way;
  logic             r_hit;

  logic [IDX_W-1:0]  w_idx, w_upd_idx;
  logic [TAG_W-1:0]  w_tag, w_upd_tag;
  logic [WAY_W-1:0]  w_hit_way, w_inv_way, w_repl_way, w_victim, w_upd_way;
  logic [DATA_W-1:0] w_upd_data;
  logic              w_hit, w_has_inv;
  logic              w_accept, w_flush, w_fill_ack, w_done;
  logic              w_touch, w_alloc, w_dwr;

  assign w_idx    = cpu_addr[IDX_W+OFF_W-1 -: IDX_W];
  assign w_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
  assign busy     = (r_state != IDLE);
  assign w_victim = w_has_inv ? w_inv_way : w_repl_way;

  // Tag match across the indexed set and lowest-index invalid way search
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  generate
    if (REPL_MODE == 1) begin : g_lru
      // Oldest way (age WAYS-1) is the replacement candidate
      always_comb begin
        w_repl_way = '0;
        for (int w = 0; w < WAYS; w++)
          if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) w_repl_way = WAY_W'(w);
      end
    end else begin : g_fifo
      assign w_repl_way = r_ptr[w_idx];
    end
  endgenerate

  // Next-state logic; flush has priority over a same-cycle request
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_flush      = 1'b0;
    w_fill_ack   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (flush) begin
          w_flush = 1'b1;
        end else if (cpu_req) begin
          w_accept = 1'b1;
          if (cpu_write)   w_state_next = MEM_WR;
          else if (!w_hit) w_state_next = MEM_RD;
        end
      end
      MEM_RD: if (mem_ack) begin
        w_state_next = IDLE;
        w_fill_ack   = 1'b1;
        w_done       = 1'b1;
      end
      MEM_WR: if (mem_ack) begin
        w_state_next = IDLE;
        w_done       = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Select which line is written/touched this cycle: a fill on ack, or the accepted access
  always_comb begin
    w_upd_idx  = w_idx;
    w_upd_way  = w_hit ? w_hit_way : w_victim;
    w_upd_tag  = w_tag;
    w_upd_data = cpu_wdata;
    w_touch    = 1'b0;
    w_alloc    = 1'b0;
    w_dwr      = 1'b0;
    if (w_fill_ack) begin
      w_upd_idx  = r_idx;
      w_upd_way  = r_way;
      w_upd_tag  = r_req_tag;
      w_upd_data = mem_rdata;
      w_touch    = 1'b1;
      w_alloc    = 1'b1;
      w_dwr      = 1'b1;
    end else if (w_accept) begin
      w_touch = w_hit || cpu_write;
      w_alloc = !w_hit && cpu_write;
      w_dwr   = cpu_write;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Valid bits, FIFO pointers and LRU ages; flush restores the reset image
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
      end
    end else if (w_flush) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
      end
    end else begin
      if (w_alloc) begin
        r_valid[w_upd_idx][w_upd_way] <= 1'b1;
        r_ptr[w_upd_idx]              <= r_ptr[w_upd_idx] + WAY_W'(1);
      end
      if (w_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == w_upd_way)
            r_age[w_upd_idx][w] <= '0;
          else if (r_age[w_upd_idx][w] < r_age[w_upd_idx][w_upd_way])
            r_age[w_upd_idx][w] <= r_age[w_upd_idx][w] + WAY_W'(1);
        end
      end
    end
  end

  // Data and tag arrays; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (w_dwr)   r_data[w_upd_idx][w_upd_way] <= w_upd_data;
    if (w_alloc) r_tag[w_upd_idx][w_upd_way]  <= w_upd_tag;
  end

  // CPU response, memory port and lookup counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_way    <= '0;
      mem_req    <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      r_idx      <= '0;
      r_req_tag  <= '0;
      r_way      <= '0;
      r_hit      <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      if (w_accept) begin
        if (w_hit) hit_count  <= hit_count + 32'd1;
        else       miss_count <= miss_count + 32'd1;
        r_idx     <= w_idx;
        r_req_tag <= w_tag;
        r_way     <= w_upd_way;
        r_hit     <= w_hit;
        if (!cpu_write && w_hit) begin
          cpu_ready <= 1'b1;
          cpu_hit   <= 1'b1;
          cpu_way   <= w_hit_way;
          cpu_rdata <= r_data[w_idx][w_hit_way];
        end else begin
          mem_req   <= 1'b1;
          mem_write <= cpu_write;
          mem_addr  <= cpu_addr & c_line_mask;
          if (cpu_write) mem_wdata <= cpu_wdata;
        end
      end else if (w_done) begin
        mem_req   <= 1'b0;
        mem_write <= 1'b0;
        cpu_ready <= 1'b1;
        cpu_hit   <= r_hit;
        cpu_way   <= r_way;
        if (r_state == MEM_RD) cpu_rdata <= mem_rdata;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache_param.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_set_assoc_cache_param                                     |
// | Description : Drives a FIFO cache (index 0) and an LRU cache (index 1)     |
// |               with identical requests and compares against a line model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_set_assoc_cache_param;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int WAYS   = 4;
  localparam int SETS   = 4;
  localparam int OFF_W  = 2;
  localparam int IDX_W  = 2;
  localparam int WAY_W  = 2;

  logic clk = 1'b0;
  logic reset;
  logic cpu_req, cpu_write, flush;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;

  logic [DATA_W-1:0] cpu_rdata_v [2];
  logic              cpu_ready_v [2];
  logic              cpu_hit_v   [2];
  logic [WAY_W-1:0]  cpu_way_v   [2];
  logic              busy_v      [2];
  logic              mem_req_v   [2];
  logic              mem_write_v [2];
  logic [ADDR_W-1:0] mem_addr_v  [2];
  logic [DATA_W-1:0] mem_wdata_v [2];
  logic [DATA_W-1:0] mem_rdata_v [2];
  logic              mem_ack_v   [2];
  logic [31:0]       hit_cnt_v   [2];
  logic [31:0]       miss_cnt_v  [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  set_assoc_cache_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .REPL_MODE(0)) u_fifo (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .flush(flush), .cpu_rdata(cpu_rdata_v[0]), .cpu_ready(cpu_ready_v[0]),
    .cpu_hit(cpu_hit_v[0]), .cpu_way(cpu_way_v[0]), .busy(busy_v[0]), .mem_req(mem_req_v[0]),
    .mem_write(mem_write_v[0]), .mem_addr(mem_addr_v[0]), .mem_wdata(mem_wdata_v[0]),
    .mem_rdata(mem_rdata_v[0]), .mem_ack(mem_ack_v[0]), .hit_count(hit_cnt_v[0]), .miss_count(miss_cnt_v[0]));

  set_assoc_cache_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .REPL_MODE(1)) u_lru (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .flush(flush), .cpu_rdata(cpu_rdata_v[1]), .cpu_ready(cpu_ready_v[1]),
    .cpu_hit(cpu_hit_v[1]), .cpu_way(cpu_way_v[1]), .busy(busy_v[1]), .mem_req(mem_req_v[1]),
    .mem_write(mem_write_v[1]), .mem_addr(mem_addr_v[1]), .mem_wdata(mem_wdata_v[1]),
    .mem_rdata(mem_rdata_v[1]), .mem_ack(mem_ack_v[1]), .hit_count(hit_cnt_v[1]), .miss_count(miss_cnt_v[1]));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: lines, FIFO counters, LRU timestamps ----------------
  bit          m_valid [2][SETS][WAYS];
  int          m_tag   [2][SETS][WAYS];
  logic [31:0] m_data  [2][SETS][WAYS];
  longint      m_stamp [2][SETS][WAYS];
  int          m_ptr   [2][SETS];
  int unsigned m_hits  [2];
  int unsigned m_miss  [2];
  longint      tick = 0;

  task automatic model_flush();
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < SETS; s++) begin
        m_ptr[m][s] = 0;
        for (int w = 0; w < WAYS; w++) begin
          m_valid[m][s][w] = 0;
          m_stamp[m][s][w] = -w;
        end
      end
  endtask

  task automatic model_reset();
    model_flush();
    for (int m = 0; m < 2; m++) begin
      m_hits[m] = 0;
      m_miss[m] = 0;
    end
  endtask

  task automatic predict(input int m, input bit wr, input int a, input logic [31:0] d,
                         input logic [31:0] fill, output bit hit, output int way, output logic [31:0] rd);
    int idx, tag, best;
    idx = (a >> OFF_W) % SETS;
    tag = a >> (OFF_W + IDX_W);
    hit = 0;
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[m][idx][w] && m_tag[m][idx][w] == tag) begin hit = 1; way = w; end
    if (hit) begin
      m_hits[m]++;
      if (wr) m_data[m][idx][way] = d;
    end else begin
      m_miss[m]++;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[m][idx][w]) way = w;
      if (way < 0) begin
        if (m == 0) way = m_ptr[m][idx];
        else begin
          best = 0;
          for (int w = 1; w < WAYS; w++) if (m_stamp[m][idx][w] < m_stamp[m][idx][best]) best = w;
          way = best;
        end
      end
      m_valid[m][idx][way] = 1;
      m_tag[m][idx][way]   = tag;
      m_data[m][idx][way]  = wr ? d : fill;
      m_ptr[m][idx]        = (m_ptr[m][idx] + 1) % WAYS;
    end
    rd = m_data[m][idx][way];
    tick++;
    m_stamp[m][idx][way] = tick;
  endtask

  // ---------------- memory responder ----------------
  int          ack_lat   [2];
  logic [31:0] fill_v    [2];
  bit          exp_mem   [2];
  logic [15:0] exp_maddr [2];
  bit          exp_mwr   [2];
  logic [31:0] exp_mwd   [2];
  int          ack_cyc   [2];

  initial begin
    bit          in_txn [2];
    bit          acked  [2];
    int          wcnt   [2];
    logic [15:0] cap_a  [2];
    logic        cap_w  [2];
    logic [31:0] cap_d  [2];
    for (int g = 0; g < 2; g++) begin
      mem_ack_v[g] = 0; mem_rdata_v[g] = '0; in_txn[g] = 0; acked[g] = 0; wcnt[g] = 0; ack_cyc[g] = -10;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (acked[g]) begin
          mem_ack_v[g] = 0;
          acked[g] = 0;
          check_eq("mem_req_drop", mem_req_v[g], 0);
        end else if (mem_req_v[g] && !reset) begin
          if (!in_txn[g]) begin
            in_txn[g] = 1;
            wcnt[g] = 0;
            cap_a[g] = mem_addr_v[g]; cap_w[g] = mem_write_v[g]; cap_d[g] = mem_wdata_v[g];
            check_eq("mem_req_expected", 1, exp_mem[g]);
            check_eq("mem_addr", mem_addr_v[g], exp_maddr[g]);
            check_eq("mem_write", mem_write_v[g], exp_mwr[g]);
            if (exp_mwr[g]) check_eq("mem_wdata", mem_wdata_v[g], exp_mwd[g]);
          end else begin
            check_eq("mem_stable", {mem_write_v[g], mem_addr_v[g], mem_wdata_v[g]}, {cap_w[g], cap_a[g], cap_d[g]});
          end
          if (wcnt[g] >= ack_lat[g]) begin
            mem_ack_v[g] = 1; mem_rdata_v[g] = fill_v[g]; ack_cyc[g] = cyc; acked[g] = 1; in_txn[g] = 0;
          end else begin
            wcnt[g]++;
          end
        end else begin
          in_txn[g] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] last_rdata [2];
  logic        last_hit   [2];
  int          last_way   [2];

  task automatic do_op(input bit wr, input logic [15:0] a, input logic [31:0] d, input int lat,
                       input bit poke, input logic [31:0] fill);
    bit eh [2]; int ew [2]; logic [31:0] er [2]; bit need [2]; bit done [2]; int acc;
    for (int g = 0; g < 2; g++) begin
      fill_v[g] = fill; ack_lat[g] = lat;
      predict(g, wr, int'(a), d, fill, eh[g], ew[g], er[g]);
      need[g] = wr || !eh[g];
      exp_mem[g] = need[g]; exp_maddr[g] = a & 16'hFFFC; exp_mwr[g] = wr; exp_mwd[g] = d;
      done[g] = 0;
    end
    @(negedge clk);
    cpu_req = 1; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_req = 0;
    acc = cyc;
    for (int k = 0; k < 60 && !(done[0] && done[1]); k++) begin
      if (k > 0) @(negedge clk);
      if (poke && k == 1 && busy_v[0] && busy_v[1]) begin
        cpu_req = 1; cpu_write = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = $urandom;
      end else begin
        cpu_req = 0;
      end
      for (int g = 0; g < 2; g++) begin
        if (k == 0) check_eq("busy", busy_v[g], need[g]);
        if (!done[g] && cpu_ready_v[g]) begin
          done[g] = 1;
          check_eq(g ? "lru_hit" : "fifo_hit", cpu_hit_v[g], eh[g]);
          check_eq(g ? "lru_way" : "fifo_way", cpu_way_v[g], ew[g]);
          if (!wr) check_eq("rdata", cpu_rdata_v[g], er[g]);
          check_eq("latency", cyc, need[g] ? ack_cyc[g] + 1 : acc);
          check_eq("hit_count", hit_cnt_v[g], m_hits[g]);
          check_eq("miss_count", miss_cnt_v[g], m_miss[g]);
          last_rdata[g] = cpu_rdata_v[g]; last_hit[g] = cpu_hit_v[g]; last_way[g] = cpu_way_v[g];
        end else if (done[g]) begin
          check_eq("ready_pulse", cpu_ready_v[g], 0);
        end
      end
    end
    cpu_req = 0;
    for (int g = 0; g < 2; g++) begin
      if (!done[g]) check_eq("ready_timeout", 0, 1);
      exp_mem[g] = 0;
    end
  endtask

  task automatic do_flush(input bit with_req);
    @(negedge clk);
    flush = 1; cpu_req = with_req; cpu_write = 1'($urandom); cpu_addr = 16'($urandom);
    @(negedge clk);
    flush = 0; cpu_req = 0;
    model_flush();
    for (int g = 0; g < 2; g++) begin
      check_eq("flush_busy", {busy_v[g], mem_req_v[g], cpu_ready_v[g]}, 3'b000);
      check_eq("flush_hits", hit_cnt_v[g], m_hits[g]);
      check_eq("flush_miss", miss_cnt_v[g], m_miss[g]);
    end
  endtask

  initial begin
    reset = 1; cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0; flush = 0;
    for (int g = 0; g < 2; g++) begin
      exp_mem[g] = 0; exp_maddr[g] = '0; exp_mwr[g] = 0; exp_mwd[g] = '0; ack_lat[g] = 0; fill_v[g] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_eq("reset_cpu", {cpu_rdata_v[g], cpu_ready_v[g], cpu_hit_v[g], cpu_way_v[g], busy_v[g]}, '0);
      check_eq("reset_mem", {mem_req_v[g], mem_write_v[g], mem_addr_v[g], mem_wdata_v[g]}, '0);
      check_eq("reset_cnt", {hit_cnt_v[g], miss_cnt_v[g]}, '0);
    end
    reset = 0;

    // Read miss then re-read hit
    do_op(0, 16'h0400, 32'h0, 3, 0, 32'hDEAD_BEEF);
    check_eq("tp_miss_rdata", last_rdata[0], 32'hDEAD_BEEF);
    check_eq("tp_miss_way", last_way[0], 0);
    check_eq("tp_miss_count", miss_cnt_v[0], 1);
    do_op(0, 16'h0400, 32'h0, 0, 0, 32'h0);
    check_eq("tp_hit", last_hit[0], 1);
    check_eq("tp_hit_count", hit_cnt_v[0], 1);

    // Write hit goes through, following read returns new data
    do_op(1, 16'h0400, 32'h1234_5678, 2, 0, 32'h0);
    do_op(0, 16'h0400, 32'h0, 0, 0, 32'h0);
    check_eq("tp_wr_readback", last_rdata[0], 32'h1234_5678);

    // FIFO: fifth tag in set 0 lands in way 0, evicted tag misses
    do_flush(0);
    for (int t = 1; t <= 5; t++) do_op(0, 16'(t << 4), 32'h0, t % 3, 0, $urandom);
    check_eq("tp_fifo_wrap", last_way[0], 0);
    do_op(0, 16'h0010, 32'h0, 1, 0, $urandom);
    check_eq("tp_fifo_evicted", last_hit[0], 0);

    // LRU: fill 4 ways, touch way 0, miss evicts way 1
    do_flush(0);
    for (int t = 1; t <= 4; t++) do_op(0, 16'(t << 4), 32'h0, 1, 0, $urandom);
    do_op(0, 16'h0010, 32'h0, 0, 0, 32'h0);
    do_op(0, 16'h0050, 32'h0, 1, 0, $urandom);
    check_eq("tp_lru_victim", last_way[1], 1);
    check_eq("tp_fifo_victim", last_way[0], 0);

    // Requests while busy and alongside flush are dropped
    do_op(1, 16'h0060, 32'hA5A5_0001, 4, 1, 32'h0);
    do_flush(1);
    do_op(0, 16'h0050, 32'h0, 1, 0, $urandom);
    check_eq("tp_after_flush_miss", last_hit[1], 0);

    // Reset during a pending fill
    for (int g = 0; g < 2; g++) begin
      ack_lat[g] = 20; exp_mem[g] = 1; exp_maddr[g] = 16'h0800; exp_mwr[g] = 0;
    end
    @(negedge clk);
    cpu_req = 1; cpu_write = 0; cpu_addr = 16'h0800;
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    reset = 1;
    #1;
    for (int g = 0; g < 2; g++) begin
      check_eq("rst_mem_req", mem_req_v[g], 0);
      check_eq("rst_state", {busy_v[g], cpu_ready_v[g]}, 2'b00);
      check_eq("rst_counters", {hit_cnt_v[g], miss_cnt_v[g]}, '0);
    end
    @(negedge clk);
    reset = 0;
    model_reset();
    for (int g = 0; g < 2; g++) exp_mem[g] = 0;
    @(negedge clk);
    do_op(0, 16'h0800, 32'h0, 1, 0, $urandom);
    check_eq("tp_rst_not_filled", last_hit[0], 0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        do_flush(1'($urandom_range(0, 1)));
      end else begin
        do_op($urandom_range(0, 2) == 0,
              16'(($urandom_range(0, 5) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3)),
              $urandom, $urandom_range(0, 4), $urandom_range(0, 7) == 0, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
